// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and defaults for the main-memory word protocol
package mem_if_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic int idx_width(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - cycle counter that flags when a wait has lasted LIMIT cycles
module mem_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the edge that would complete the LIMIT-th waiting cycle.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_line_initiator.sv
// rtl/mem_line_initiator.sv - line refill/write-back initiator on the req/ready/done memory port
// Optional watchdog abort enabled by defining MEM_LINE_TIMEOUT_EN.
module mem_line_initiator
  import mem_if_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] cmd_wline,
  output logic                         fill_valid,
  output logic [idx_width(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         cmd_done,
  output logic                         cmd_err,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  input  logic                         mem_done,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int IDX_W = idx_width(LINE_WORDS);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         next_idx;
  logic [ADDR_W-IDX_W-1:0]  base_line;
  logic                     we_q;
  logic [DATA_W-1:0]        wbuf [LINE_WORDS];
  logic                     timeout_hit;
  logic                     unused_bits;

  assign next_idx    = idx + 1'b1;
  assign unused_bits = ^cmd_addr[IDX_W-1:0];

`ifdef MEM_LINE_TIMEOUT_EN
  logic wd_clear;
  assign wd_clear = (state == ISSUE) && mem_ready;

  mem_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (state == WAIT),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      base_line  <= '0;
      we_q       <= 1'b0;
      cmd_ready  <= 1'b1;
      fill_valid <= 1'b0;
      fill_idx   <= '0;
      fill_data  <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) wbuf[i] <= '0;
    end else begin
      fill_valid <= 1'b0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            base_line <= cmd_addr[ADDR_W-1:IDX_W];
            we_q      <= cmd_we;
            for (int i = 0; i < LINE_WORDS; i++) wbuf[i] <= cmd_wline[i*DATA_W +: DATA_W];
            idx       <= '0;
            cmd_ready <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= cmd_we;
            mem_addr  <= {cmd_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
            mem_wdata <= cmd_we ? cmd_wline[DATA_W-1:0] : '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Address, we and wdata stay put here: memory samples them at completion.
          if (mem_done) begin
            if (!we_q) begin
              fill_valid <= 1'b1;
              fill_idx   <= idx;
              fill_data  <= mem_rdata;
            end
            if (idx == IDX_W'(LINE_WORDS - 1)) begin
              cmd_done  <= 1'b1;
              cmd_ready <= 1'b1;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              state     <= IDLE;
            end else begin
              idx       <= next_idx;
              mem_req   <= 1'b1;
              mem_addr  <= {base_line, next_idx};
              mem_wdata <= we_q ? wbuf[next_idx] : '0;
              state     <= ISSUE;
            end
          end else if (timeout_hit) begin
            cmd_err   <= 1'b1;
            cmd_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_initiator.sv
// tb/tb_mem_line_initiator.sv - directed scoreboard bench for mem_line_initiator
module tb_mem_line_initiator;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LW     = 4;
  localparam int IDX_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [LW*DATA_W-1:0] cmd_wline;
  logic                 fill_valid;
  logic [IDX_W-1:0]     fill_idx;
  logic [DATA_W-1:0]    fill_data;
  logic                 cmd_done;
  logic                 cmd_err;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_ready;
  logic                 mem_done;
  logic [DATA_W-1:0]    mem_rdata;

  always #5 clk = ~clk;

  mem_line_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wline(cmd_wline),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic we; logic [DATA_W-1:0] wdata; } txn_t;
  typedef struct { logic [IDX_W-1:0] idx; logic [DATA_W-1:0] data; } fill_t;

  txn_t  exp_txn[$];
  fill_t exp_fill[$];

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int done_count = 0;
  int err_count = 0;
  int fill_count = 0;
  int ready_stall = 0;
  int lat_cnt = 0;
  int latency = 8;
  bit hang = 0;
  bit busy = 0;
  logic [DATA_W-1:0] mem [0:65535];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory model: acts on falling edges, samples address/we/wdata at completion.
  initial begin
    txn_t t;
    for (int i = 0; i < 65536; i++) mem[i] = DATA_W'(i);
    mem_ready = 1'b1; mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (!rst_n) begin
        busy = 0; mem_ready = 1'b1;
      end else if (busy) begin
        mem_ready = 1'b0;
        if (lat_cnt > 1) lat_cnt--;
        else if (!hang) begin
          if (exp_txn.size() == 0) check("txn_unexpected", {48'h0, mem_addr}, 64'hFFFF_FFFF);
          else begin
            t = exp_txn.pop_front();
            check("txn_addr", 64'(mem_addr), 64'(t.addr));
            check("txn_we", 64'(mem_we), 64'(t.we));
            check("txn_wdata", 64'(mem_wdata), 64'(t.wdata));
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem[mem_addr];
          mem_done = 1'b1; mem_ready = 1'b1; busy = 0;
        end
      end else begin
        if (ready_stall > 0) begin
          mem_ready = 1'b0;
          if (mem_req) ready_stall--;
        end else mem_ready = 1'b1;
        if (mem_req && mem_ready) begin
          hs_count++; busy = 1; lat_cnt = latency;
        end
      end
    end
  end

  initial begin
    fill_t f;
    forever begin
      @(negedge clk);
      if (cmd_done) done_count++;
      if (cmd_err) err_count++;
      if (fill_valid) begin
        fill_count++;
        if (exp_fill.size() == 0) check("fill_unexpected", 64'(fill_data), 64'hFFFF_FFFF_FFFF);
        else begin
          f = exp_fill.pop_front();
          check("fill_idx", 64'(fill_idx), 64'(f.idx));
          check("fill_data", 64'(fill_data), 64'(f.data));
        end
      end
    end
  end

  task automatic expect_line(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [LW*DATA_W-1:0] wline, input bit push_fill);
    logic [ADDR_W-1:0] base;
    base = addr & ~ADDR_W'(LW - 1);
    for (int i = 0; i < LW; i++) begin
      exp_txn.push_back('{addr: base + ADDR_W'(i), we: we,
                          wdata: we ? wline[i*DATA_W +: DATA_W] : '0});
      if (!we && push_fill)
        exp_fill.push_back('{idx: IDX_W'(i), data: DATA_W'(base + ADDR_W'(i))});
    end
  endtask

  // Called just after a falling edge; offers the command for exactly one rising edge.
  task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [LW*DATA_W-1:0] wline, input bit push);
    int n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); #1; n++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    if (push) expect_line(we, addr, wline, 1'b1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wline = wline;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!cmd_done && n < 500) begin @(negedge clk); #1; n++; end
    check(name, 64'(cmd_done), 64'd1);
  endtask

  initial begin
    logic [LW*DATA_W-1:0] wl;
    logic [ADDR_W-1:0] held;
    int d0, hs0, f0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wline = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_done_err_fill", {61'd0, cmd_done, cmd_err, fill_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Refill, 8-cycle memory
    hs0 = hs_count; f0 = fill_count;
    send_cmd(1'b0, 16'h1237, '0, 1'b1);
    wait_done("refill_done");
    check("refill_handshakes", 64'(hs_count - hs0), 64'd4);
    check("refill_fills", 64'(fill_count - f0), 64'd4);
    check("refill_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk); #1;
    check("refill_done_once", 64'(done_count), 64'd1);
    check("refill_txn_left", 64'(exp_txn.size()), 64'd0);

    // Write-back
    for (int i = 0; i < LW; i++) wl[i*DATA_W +: DATA_W] = 32'hDEAD_0000 + 32'(i);
    f0 = fill_count;
    send_cmd(1'b1, 16'h0040, wl, 1'b1);
    wait_done("wb_done");
    @(negedge clk); #1;
    for (int i = 0; i < LW; i++) check("wb_mem", 64'(mem[16'h0040 + i]), 64'(32'hDEAD_0000 + 32'(i)));
    check("wb_no_fill", 64'(fill_count - f0), 64'd0);
    check("wb_mem_we_low", 64'(mem_we), 64'd0);

    // mem_ready held low during ISSUE
    ready_stall = 5; hs0 = hs_count;
    send_cmd(1'b0, 16'h0100, '0, 1'b1);
    check("stall_req_up", 64'(mem_req), 64'd1);
    held = mem_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_req_held", 64'(mem_req), 64'd1);
      check("stall_addr_held", 64'(mem_addr), 64'(held));
    end
    check("stall_no_handshake", 64'(hs_count - hs0), 64'd1);
    wait_done("stall_done");
    check("stall_handshakes", 64'(hs_count - hs0), 64'd4);

    // Busy cmd_valid ignored, back-to-back accept
    @(negedge clk); #1;
    send_cmd(1'b0, 16'h1234, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h5550;
      check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_done("b2b_first_done");
    check("b2b_ready_with_done", 64'(cmd_ready), 64'd1);
    send_cmd(1'b0, 16'h1238, '0, 1'b1);
    wait_done("b2b_second_done");
    check("b2b_txn_left", 64'(exp_txn.size()), 64'd0);

    // Reset during WAIT of word 2
    @(negedge clk); #1;
    hs0 = hs_count;
    send_cmd(1'b0, 16'h2000, '0, 1'b1);
    n = 0;
    while (hs_count - hs0 < 3 && n < 300) begin @(negedge clk); #1; n++; end
    check("rst_reach_word2", 64'(hs_count - hs0), 64'd3);
    @(negedge clk); #1;
    d0 = done_count;
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_mem_req_we", {62'd0, mem_req, mem_we}, 64'd0);
    check("midrst_mem_addr", 64'(mem_addr), 64'd0);
    check("midrst_done_fill", {62'd0, cmd_done, fill_valid}, 64'd0);
    exp_txn.delete(); exp_fill.delete();
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    hs0 = hs_count;
    repeat (20) @(negedge clk);
    #1;
    check("midrst_no_done", 64'(done_count - d0), 64'd0);
    check("midrst_no_request", 64'(hs_count - hs0), 64'd0);
    send_cmd(1'b0, 16'h3004, '0, 1'b1);
    wait_done("post_rst_done");
    @(negedge clk); #1;
    check("post_rst_done_count", 64'(done_count - d0), 64'd1);
    check("post_rst_txn_left", 64'(exp_txn.size() + exp_fill.size()), 64'd0);

`ifdef MEM_LINE_TIMEOUT_EN
    hang = 1; d0 = done_count;
    send_cmd(1'b0, 16'h4000, '0, 1'b0);
    n = 0;
    while (mem_req && n < 100) begin @(negedge clk); #1; n++; end
    n = 0;
    while (!cmd_err && n < 200) begin @(negedge clk); #1; n++; end
    check("timeout_cycles", 64'(n), 64'd64);
    check("timeout_cmd_ready", 64'(cmd_ready), 64'd1);
    check("timeout_req_we", {62'd0, mem_req, mem_we}, 64'd0);
    @(negedge clk); #1;
    check("timeout_err_pulse", 64'(cmd_err), 64'd0);
    check("timeout_no_done", 64'(done_count - d0), 64'd0);
    hang = 0; busy = 0;
`else
    check("no_cmd_err", 64'(err_count), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
